// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-requester single-outstanding memory arbiter with timeout
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_be,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_err,
  input  logic                dat_req,
  input  logic                dat_we,
  input  logic [ADDR_W-1:0]   dat_addr,
  input  logic [DATA_W-1:0]   dat_wdata,
  input  logic [DATA_W/8-1:0] dat_be,
  output logic                dat_gnt,
  output logic                dat_rvalid,
  output logic [DATA_W-1:0]   dat_rdata,
  output logic                dat_err,
  input  logic                ins_req,
  input  logic                ins_we,
  input  logic [ADDR_W-1:0]   ins_addr,
  input  logic [DATA_W-1:0]   ins_wdata,
  input  logic [DATA_W/8-1:0] ins_be,
  output logic                ins_gnt,
  output logic                ins_rvalid,
  output logic [DATA_W-1:0]   ins_rdata,
  output logic                ins_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_DBG, OWN_DAT, OWN_INS} owner_t;

  // Last WAIT count value before the timeout fires (counter holds completed idle WAIT cycles)
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  owner_t            r_owner;
  logic [7:0]        r_cnt;
  logic              r_ptr_dat;   // 0: ins favoured on a dat/ins tie, 1: dat favoured
  logic              r_dbg_rvalid, r_dat_rvalid, r_ins_rvalid;
  logic              r_dbg_err, r_dat_err, r_ins_err;
  logic [DATA_W-1:0] r_dbg_rdata, r_dat_rdata, r_ins_rdata;

  logic              w_can_issue;
  logic              w_gnt_dbg, w_gnt_dat, w_gnt_ins, w_gnt_any;
  logic              w_mem_done, w_timeout, w_rsp;
  logic [DATA_W-1:0] w_rsp_data;

  // Grant decision: dbg first, then round-robin between dat and ins; never during reset
  always_comb begin
    w_can_issue = !rst && (r_state == S_IDLE) && mem_ready;
    w_gnt_dbg   = w_can_issue && dbg_req;
    w_gnt_dat   = w_can_issue && !dbg_req && dat_req && (!ins_req || r_ptr_dat);
    w_gnt_ins   = w_can_issue && !dbg_req && ins_req && (!dat_req || !r_ptr_dat);
    w_gnt_any   = w_gnt_dbg || w_gnt_dat || w_gnt_ins;
  end

  // Memory request attributes follow the winner in the grant cycle
  always_comb begin
    mem_we    = ins_we;
    mem_addr  = ins_addr;
    mem_wdata = ins_wdata;
    mem_be    = ins_be;
    if (w_gnt_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_be    = dbg_be;
    end else if (w_gnt_dat) begin
      mem_we    = dat_we;
      mem_addr  = dat_addr;
      mem_wdata = dat_wdata;
      mem_be    = dat_be;
    end
  end

  // Response qualification: memory answer wins over a coincident timeout
  always_comb begin
    w_mem_done = (r_state == S_WAIT) && mem_rvalid;
    w_timeout  = (r_state == S_WAIT) && !mem_rvalid && (r_cnt == LP_CNT_LAST);
    w_rsp      = w_mem_done || w_timeout;
    w_rsp_data = mem_rvalid ? mem_rdata : '0;
  end

  assign mem_req    = w_gnt_any;
  assign dbg_gnt    = w_gnt_dbg;
  assign dat_gnt    = w_gnt_dat;
  assign ins_gnt    = w_gnt_ins;
  assign dbg_rvalid = r_dbg_rvalid;
  assign dat_rvalid = r_dat_rvalid;
  assign ins_rvalid = r_ins_rvalid;
  assign dbg_err    = r_dbg_err;
  assign dat_err    = r_dat_err;
  assign ins_err    = r_ins_err;
  assign dbg_rdata  = r_dbg_rdata;
  assign dat_rdata  = r_dat_rdata;
  assign ins_rdata  = r_ins_rdata;

  // Arbiter FSM, round-robin pointer, timeout counter and registered response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_DBG;
      r_cnt        <= '0;
      r_ptr_dat    <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_dat_rvalid <= 1'b0;
      r_ins_rvalid <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_dat_err    <= 1'b0;
      r_ins_err    <= 1'b0;
      r_dbg_rdata  <= '0;
      r_dat_rdata  <= '0;
      r_ins_rdata  <= '0;
    end else begin
      r_dbg_rvalid <= w_rsp && (r_owner == OWN_DBG);
      r_dat_rvalid <= w_rsp && (r_owner == OWN_DAT);
      r_ins_rvalid <= w_rsp && (r_owner == OWN_INS);
      r_dbg_err    <= w_timeout && (r_owner == OWN_DBG);
      r_dat_err    <= w_timeout && (r_owner == OWN_DAT);
      r_ins_err    <= w_timeout && (r_owner == OWN_INS);
      r_dbg_rdata  <= (w_rsp && (r_owner == OWN_DBG)) ? w_rsp_data : '0;
      r_dat_rdata  <= (w_rsp && (r_owner == OWN_DAT)) ? w_rsp_data : '0;
      r_ins_rdata  <= (w_rsp && (r_owner == OWN_INS)) ? w_rsp_data : '0;
      if (r_state == S_IDLE) begin
        if (w_gnt_any) begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
          if (w_gnt_dbg) begin
            r_owner <= OWN_DBG;
          end else if (w_gnt_dat) begin
            r_owner   <= OWN_DAT;
            r_ptr_dat <= 1'b0;
          end else begin
            r_owner   <= OWN_INS;
            r_ptr_dat <= 1'b1;
          end
        end
      end else begin
        if (w_rsp) begin
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [3:0]    dbg_be;
    logic          dat_req, dat_we, dat_gnt, dat_rvalid, dat_err;
    logic [AW-1:0] dat_addr;
    logic [DW-1:0] dat_wdata, dat_rdata;
    logic [3:0]    dat_be;
    logic          ins_req, ins_we, ins_gnt, ins_rvalid, ins_err;
    logic [AW-1:0] ins_addr;
    logic [DW-1:0] ins_wdata, ins_rdata;
    logic [3:0]    ins_be;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    int total;
    int bad;

    logic [7:0] exp_ins_gnt;
    logic [7:0] exp_dat_gnt;
    logic [7:0] exp_ins_rv;
    logic [7:0] exp_dat_rv;
    logic [7:0] pat_mem_rv;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_err(dbg_err),
        .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata),
        .dat_be(dat_be), .dat_gnt(dat_gnt), .dat_rvalid(dat_rvalid), .dat_rdata(dat_rdata),
        .dat_err(dat_err),
        .ins_req(ins_req), .ins_we(ins_we), .ins_addr(ins_addr), .ins_wdata(ins_wdata),
        .ins_be(ins_be), .ins_gnt(ins_gnt), .ins_rvalid(ins_rvalid), .ins_rdata(ins_rdata),
        .ins_err(ins_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_ins_gnt = 8'b0001_0001;
        exp_dat_gnt = 8'b0100_0100;
        exp_ins_rv  = 8'b0100_0100;
        exp_dat_rv  = 8'b0001_0000;
        pat_mem_rv  = 8'b1010_1010;

        rst = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_be = 4'h0;
        dat_req = 1'b0; dat_we = 1'b0; dat_addr = 32'h0; dat_wdata = 32'h0; dat_be = 4'h0;
        ins_req = 1'b1; ins_we = 1'b0; ins_addr = 32'h0; ins_wdata = 32'h0; ins_be = 4'hF;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset cycle: no grant even with a pending request and a ready memory
        smp();
        chk("rst_ins_gnt", ins_gnt, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        cyc();
        ins_req = 1'b0;
        cyc();
        rst = 1'b0;
        smp();
        chk("rst_ins_rvalid", ins_rvalid, 1'b0);
        chk("rst_dat_rvalid", dat_rvalid, 1'b0);
        chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rst_ins_rdata", ins_rdata, 32'h0);

        // Single read: grant T, memory answers T+2, response in T+3 only
        cyc();
        ins_req = 1'b1; ins_addr = 32'h100;
        smp();
        chk("rd_ins_gnt", ins_gnt, 1'b1);
        chk("rd_mem_req", mem_req, 1'b1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_mem_we", mem_we, 1'b0);
        chk("rd_dat_gnt", dat_gnt, 1'b0);
        cyc();
        ins_req = 1'b0;
        smp();
        chk("rd_t1_mem_req", mem_req, 1'b0);
        chk("rd_t1_rvalid", ins_rvalid, 1'b0);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        smp();
        chk("rd_t2_rvalid", ins_rvalid, 1'b0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        smp();
        chk("rd_t3_rvalid", ins_rvalid, 1'b1);
        chk("rd_t3_rdata", ins_rdata, 32'hDEADBEEF);
        chk("rd_t3_err", ins_err, 1'b0);
        cyc();
        smp();
        chk("rd_t4_rvalid", ins_rvalid, 1'b0);

        // Reset again so the pointer favours ins, then contend dat against ins
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dat_req = 1'b1; dat_addr = 32'h200;
        ins_req = 1'b1; ins_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) cyc();
            mem_rvalid = pat_mem_rv[i];
            mem_rdata  = 32'h1000 + 32'(i);
            smp();
            chk("rr_ins_gnt", ins_gnt, exp_ins_gnt[i]);
            chk("rr_dat_gnt", dat_gnt, exp_dat_gnt[i]);
            chk("rr_ins_rvalid", ins_rvalid, exp_ins_rv[i]);
            chk("rr_dat_rvalid", dat_rvalid, exp_dat_rv[i]);
            if (exp_ins_rv[i]) chk("rr_ins_rdata", ins_rdata, 32'h1000 + 32'(i - 1));
            if (exp_dat_rv[i]) chk("rr_dat_rdata", dat_rdata, 32'h1000 + 32'(i - 1));
        end
        cyc();
        dat_req = 1'b0; ins_req = 1'b0; mem_rvalid = 1'b0;
        smp();
        chk("rr_last_dat_rvalid", dat_rvalid, 1'b1);

        // Priority: dbg first, then ins (pointer untouched by dbg), then dat
        cyc();
        dbg_req = 1'b1; dbg_addr = 32'hD0;
        dat_req = 1'b1; dat_addr = 32'h20; dat_we = 1'b1; dat_wdata = 32'hCAFE0001; dat_be = 4'h3;
        ins_req = 1'b1; ins_addr = 32'h10;
        smp();
        chk("pr_dbg_gnt", dbg_gnt, 1'b1);
        chk("pr_p0_ins_gnt", ins_gnt, 1'b0);
        chk("pr_p0_dat_gnt", dat_gnt, 1'b0);
        chk("pr_p0_addr", mem_addr, 32'hD0);
        cyc();
        dbg_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        smp();
        chk("pr_p1_mem_req", mem_req, 1'b0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("pr_ins_gnt", ins_gnt, 1'b1);
        chk("pr_p2_dat_gnt", dat_gnt, 1'b0);
        chk("pr_dbg_rvalid", dbg_rvalid, 1'b1);
        chk("pr_dbg_rdata", dbg_rdata, 32'h77);
        cyc();
        ins_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88;
        smp();
        chk("pr_p3_dbg_rvalid", dbg_rvalid, 1'b0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("pr_dat_gnt", dat_gnt, 1'b1);
        chk("pr_ins_rvalid", ins_rvalid, 1'b1);
        chk("pr_dat_we", mem_we, 1'b1);
        chk("pr_dat_addr", mem_addr, 32'h20);
        chk("pr_dat_wdata", mem_wdata, 32'hCAFE0001);
        chk("pr_dat_be", mem_be, 4'h3);
        cyc();
        dat_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("pr_dat_rvalid", dat_rvalid, 1'b1);
        chk("pr_dat_err", dat_err, 1'b0);

        // Timeout with TIMEOUT=4: dat write granted T, error response in T+5
        cyc();
        dat_req = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        smp();
        chk("to_dat_gnt", dat_gnt, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            dat_req = 1'b0;
            smp();
            chk("to_wait_rvalid", dat_rvalid, 1'b0);
            chk("to_wait_mem_req", mem_req, 1'b0);
        end
        cyc();
        smp();
        chk("to_rvalid", dat_rvalid, 1'b1);
        chk("to_err", dat_err, 1'b1);
        chk("to_rdata", dat_rdata, 32'h0);
        cyc();
        smp();
        chk("to_t6_rvalid", dat_rvalid, 1'b0);
        chk("to_t6_err", dat_err, 1'b0);
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("to_late_dat_rvalid", dat_rvalid, 1'b0);
        chk("to_late_ins_rvalid", ins_rvalid, 1'b0);
        chk("to_late_dbg_rvalid", dbg_rvalid, 1'b0);

        // Memory answer on the timeout cycle gives a normal response
        cyc();
        ins_req = 1'b1; ins_addr = 32'h44;
        smp();
        chk("tc_ins_gnt", ins_gnt, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            ins_req = 1'b0;
        end
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        smp();
        chk("tc_t4_rvalid", ins_rvalid, 1'b0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("tc_rvalid", ins_rvalid, 1'b1);
        chk("tc_err", ins_err, 1'b0);
        chk("tc_rdata", ins_rdata, 32'h12345678);

        // Backpressure: no grant while memory is not ready
        cyc();
        mem_ready = 1'b0; ins_req = 1'b1; ins_addr = 32'h500;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) cyc();
            smp();
            chk("bp_ins_gnt", ins_gnt, 1'b0);
            chk("bp_mem_req", mem_req, 1'b0);
        end
        cyc();
        mem_ready = 1'b1;
        smp();
        chk("bp_rise_gnt", ins_gnt, 1'b1);
        chk("bp_rise_addr", mem_addr, 32'h500);

        // Reset during WAIT abandons the access; stray answer afterwards is ignored
        cyc();
        ins_req = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hEEEE;
        smp();
        chk("rw_after_rst_rvalid", ins_rvalid, 1'b0);
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("rw_stray_rvalid", ins_rvalid, 1'b0);
        chk("rw_stray_rdata", ins_rdata, 32'h0);
        cyc();
        ins_req = 1'b1; ins_addr = 32'h600;
        smp();
        chk("rw_new_gnt", ins_gnt, 1'b1);
        cyc();
        ins_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABC;
        cyc();
        mem_rvalid = 1'b0;
        smp();
        chk("rw_new_rvalid", ins_rvalid, 1'b1);
        chk("rw_new_rdata", ins_rdata, 32'hABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
